vga_timing_gen: RTL

- Generates 640x480@60 Hz VGA timing from the 100 MHz board clock.
- Drives hCount/vCount/bright into the pixel-colour logic, and hSync/vSync to the connector.
- Also provides frame-synchronous event pulses (frame_start, move_tick) so game logic updates positions only between frames.
- Sits between the top level and all rgb-producing blocks; it is the producing end of the hCount/vCount/bright interface.

---
 rtl/vga_timing_gen_if.sv | 22 ++
 rtl/vga_timing_gen.sv | 118 +++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - timing/event bundle from the VGA timing generator to pixel logic
interface vga_timing_gen_if;
    logic        pix_en;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        hSync;
    logic        vSync;
    logic        bright;
    logic        frame_start;
    logic        move_tick;
    logic [15:0] frame_count;

    modport master (
        output pix_en, hCount, vCount, hSync, vSync, bright,
               frame_start, move_tick, frame_count
    );

    modport slave (
        input  pix_en, hCount, vCount, hSync, vSync, bright,
               frame_start, move_tick, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA timing with frame-synchronous event pulses
module vga_timing_gen #(
    parameter int CLK_DIV         = 4,
    parameter int H_TOTAL         = 800,
    parameter int H_SYNC          = 96,
    parameter int H_ACT_START     = 144,
    parameter int H_ACT           = 640,
    parameter int V_TOTAL         = 525,
    parameter int V_SYNC          = 2,
    parameter int V_ACT_START     = 35,
    parameter int V_ACT           = 480,
    parameter int FRAMES_PER_MOVE = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    vga_timing_gen_if.master  vga
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_SYNC_W  = 10'(H_SYNC);
    localparam logic [9:0]       V_SYNC_W  = 10'(V_SYNC);
    localparam logic [9:0]       H_VIS_LO  = 10'(H_ACT_START);
    localparam logic [9:0]       H_VIS_HI  = 10'(H_ACT_START + H_ACT);
    localparam logic [9:0]       V_VIS_LO  = 10'(V_ACT_START);
    localparam logic [9:0]       V_VIS_HI  = 10'(V_ACT_START + V_ACT);
    localparam logic [7:0]       MOVE_LAST = 8'(FRAMES_PER_MOVE - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pix_en_q, pix_en_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             bright_q, bright_d;
    logic             frame_start_q, frame_start_d;
    logic             move_tick_q, move_tick_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic [7:0]       move_cnt_q, move_cnt_d;

    always_comb begin
        div_cnt_d     = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        pix_en_d      = (div_cnt_q == DIV_LAST);
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_start_d = 1'b0;
        move_tick_d   = 1'b0;
        frame_count_d = frame_count_q;
        move_cnt_d    = move_cnt_q;

        if (pix_en_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d       = '0;
                    frame_start_d = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    if (move_cnt_q == MOVE_LAST) begin
                        move_cnt_d  = '0;
                        move_tick_d = 1'b1;
                    end else begin
                        move_cnt_d  = move_cnt_q + 8'd1;
                    end
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end

        // Decoded from next-state counters so they align with hCount/vCount
        hsync_d  = (h_cnt_d >= H_SYNC_W);
        vsync_d  = (v_cnt_d >= V_SYNC_W);
        bright_d = (h_cnt_d >= H_VIS_LO) && (h_cnt_d < H_VIS_HI) &&
                   (v_cnt_d >= V_VIS_LO) && (v_cnt_d < V_VIS_HI);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q     <= '0;
            pix_en_q      <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            bright_q      <= 1'b0;
            frame_start_q <= 1'b0;
            move_tick_q   <= 1'b0;
            frame_count_q <= '0;
            move_cnt_q    <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pix_en_q      <= pix_en_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            bright_q      <= bright_d;
            frame_start_q <= frame_start_d;
            move_tick_q   <= move_tick_d;
            frame_count_q <= frame_count_d;
            move_cnt_q    <= move_cnt_d;
        end
    end

    assign vga.pix_en      = pix_en_q;
    assign vga.hCount      = h_cnt_q;
    assign vga.vCount      = v_cnt_q;
    assign vga.hSync       = hsync_q;
    assign vga.vSync       = vsync_q;
    assign vga.bright      = bright_q;
    assign vga.frame_start = frame_start_q;
    assign vga.move_tick   = move_tick_q;
    assign vga.frame_count = frame_count_q;
endmodule
